// File: rtl/mont_exp_pkg.sv
// Shared types and default widths for the Montgomery exponentiation sequencer.
package mont_exp_pkg;

  localparam int DEF_WIDTH   = 512;
  localparam int DEF_E_WIDTH = 512;

  typedef enum logic [2:0] {
    IDLE,
    CONV_IN,
    SQR,
    MUL,
    CONV_OUT,
    FIN
  } state_t;

  typedef enum logic {
    ISSUE,
    WAIT
  } phase_t;

endpackage

// File: rtl/exp_msb_detect.sv
// Priority encoder giving the index of the most-significant set exponent bit.
// Only instantiated by mont_exp_ctrl when SKIP_LEADING_ZEROS_EN is defined.
module exp_msb_detect
  import mont_exp_pkg::*;
#(
  parameter int E_WIDTH = DEF_E_WIDTH,
  parameter int CNT_W   = $clog2(E_WIDTH)
) (
  input  logic [E_WIDTH-1:0] i_e,
  output logic [CNT_W-1:0]   o_msb,
  output logic               o_zero
);

  // Ascending scan: the highest set bit is the last one written.
  always_comb begin
    o_msb  = '0;
    o_zero = 1'b1;
    for (int i = 0; i < E_WIDTH; i++) begin
      if (i_e[i]) begin
        o_msb  = CNT_W'(i);
        o_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Optional macro SKIP_LEADING_ZEROS_EN starts the bit scan at the exponent's top set bit.
module mont_exp_ctrl
  import mont_exp_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int E_WIDTH = DEF_E_WIDTH,
  parameter int CNT_W   = $clog2(E_WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_rmodm,
  input  logic [WIDTH-1:0]   in_r2modm,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               mont_start,
  output logic [WIDTH-1:0]   mont_a,
  output logic [WIDTH-1:0]   mont_b,
  output logic [WIDTH-1:0]   mont_m,
  input  logic [WIDTH-1:0]   mont_result,
  input  logic               mont_done
);

  state_t             r_state, w_state_nxt;
  phase_t             r_phase, w_phase_nxt;
  logic [WIDTH-1:0]   r_x, r_m, r_r2, r_acc, r_xm, r_result;
  logic [E_WIDTH-1:0] r_e;
  logic [CNT_W-1:0]   r_idx;
  logic               r_busy, r_done;
  logic               w_mult, w_capture, w_dec, w_skip_to_out;
  logic [WIDTH-1:0]   w_a, w_b;

`ifdef SKIP_LEADING_ZEROS_EN
  logic [CNT_W-1:0] w_msb;
  logic             w_e_zero;

  exp_msb_detect #(
    .E_WIDTH (E_WIDTH),
    .CNT_W   (CNT_W)
  ) u_msb (
    .i_e    (r_e),
    .o_msb  (w_msb),
    .o_zero (w_e_zero)
  );

  assign w_skip_to_out = w_e_zero;
`else
  assign w_skip_to_out = 1'b0;
`endif

  // Operands are decoded from state so they stay stable through ISSUE and WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_dec       = 1'b0;
    w_a         = '0;
    w_b         = '0;
    w_mult      = (r_state == CONV_IN) || (r_state == SQR) ||
                  (r_state == MUL) || (r_state == CONV_OUT);
    w_capture   = w_mult && (r_phase == WAIT) && mont_done;

    if (w_mult) begin
      if (r_phase == ISSUE)
        w_phase_nxt = WAIT;
      else if (mont_done)
        w_phase_nxt = ISSUE;
    end

    case (r_state)
      IDLE: begin
        if (start)
          w_state_nxt = CONV_IN;
      end
      CONV_IN: begin
        w_a = r_x;
        w_b = r_r2;
        if (w_capture)
          w_state_nxt = w_skip_to_out ? CONV_OUT : SQR;
      end
      SQR, MUL: begin
        w_a = r_acc;
        w_b = (r_state == SQR) ? r_acc : r_xm;
        if (w_capture) begin
          if ((r_state == SQR) && r_e[r_idx])
            w_state_nxt = MUL;
          else if (r_idx == '0)
            w_state_nxt = CONV_OUT;
          else begin
            w_state_nxt = SQR;
            w_dec       = 1'b1;
          end
        end
      end
      CONV_OUT: begin
        w_a = r_acc;
        w_b = WIDTH'(1);
        if (w_capture)
          w_state_nxt = FIN;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The final product lands in result with done raised, so FIN presents a valid result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_phase  <= ISSUE;
      r_x      <= '0;
      r_m      <= '0;
      r_r2     <= '0;
      r_acc    <= '0;
      r_xm     <= '0;
      r_result <= '0;
      r_e      <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_done  <= 1'b0;
      if ((r_state == IDLE) && start) begin
        r_x    <= in_x;
        r_e    <= in_e;
        r_m    <= in_m;
        r_r2   <= in_r2modm;
        r_acc  <= in_rmodm;
        r_idx  <= CNT_W'(E_WIDTH - 1);
        r_busy <= 1'b1;
      end
      if (w_capture) begin
        if (r_state == CONV_IN) begin
          r_xm <= mont_result;
`ifdef SKIP_LEADING_ZEROS_EN
          r_idx <= w_msb;
`endif
        end else begin
          r_acc <= mont_result;
        end
        if (r_state == CONV_OUT) begin
          r_result <= mont_result;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
      end
      if (w_dec)
        r_idx <= r_idx - CNT_W'(1);
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign mont_start = w_mult && (r_phase == ISSUE);
  assign mont_a     = w_a;
  assign mont_b     = w_b;
  assign mont_m     = r_m;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with a behavioural Montgomery multiplier and modexp reference.
// Expected multiplication counts follow SKIP_LEADING_ZEROS_EN when it is defined for the build.
module tb_mont_exp_ctrl;

  localparam int W  = 512;
  localparam int EW = 512;
  localparam int W2 = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0;
  logic [EW-1:0] in_e = '0;
  logic [W-1:0]  in_m = '0;
  logic [W-1:0]  in_rmodm = '0;
  logic [W-1:0]  in_r2modm = '0;
  logic          busy, done, mont_start;
  logic [W-1:0]  result, mont_a, mont_b, mont_m;
  logic [W-1:0]  mont_result = '0;
  logic          mont_done = 1'b0;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int startCount = 0;
  int waitCycles = 0;
  int unstable = 0;
  int doneCount = 0;
  int doneCycle = 0;
  int waitLeft = 0;
  logic mdBusy = 1'b0;
  logic doneBusy = 1'b0;
  logic donePrevBusy = 1'b0;
  logic lastBusy = 1'b0;
  logic [W-1:0] capA = '0;
  logic [W-1:0] capB = '0;
  logic [W-1:0] capR = '0;
  logic [W-1:0] doneResult = '0;
  logic [W-1:0] curM = '0;

  mont_exp_ctrl #(
    .WIDTH   (W),
    .E_WIDTH (EW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_x        (in_x),
    .in_e        (in_e),
    .in_m        (in_m),
    .in_rmodm    (in_rmodm),
    .in_r2modm   (in_r2modm),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .mont_start  (mont_start),
    .mont_a      (mont_a),
    .mont_b      (mont_b),
    .mont_m      (mont_m),
    .mont_result (mont_result),
    .mont_done   (mont_done)
  );

  always #5 clk = ~clk;

  // a*b*2^-W mod m, bit-serial REDC standing in for the external multiplier
  function automatic logic [W-1:0] montMul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  // Plain modular exponentiation on double-width integers
  function automatic logic [W-1:0] modExp(input logic [W-1:0] x, input logic [EW-1:0] e,
                                          input logic [W-1:0] m);
    logic [W2-1:0] r, mm, xx;
    mm = {{W{1'b0}}, m};
    xx = {{W{1'b0}}, x};
    r  = W2'(1) % mm;
    for (int i = EW - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * xx) % mm;
    end
    return r[W-1:0];
  endfunction

  function automatic int expectedN(input logic [EW-1:0] e);
    int pc;
    pc = $countones(e);
`ifdef SKIP_LEADING_ZEROS_EN
    begin
      int msb;
      msb = -1;
      for (int i = 0; i < EW; i++) if (e[i]) msb = i;
      return (msb < 0) ? 2 : (2 + msb + 1 + pc);
    end
`else
    return 2 + EW + pc;
`endif
  endfunction

  function automatic logic [W-1:0] randWide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock step; afterwards the multiplier model reacts to the DUT's new outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    mont_done = 1'b0;
    if (reset === 1'b1) begin
      mdBusy = 1'b0;
    end else if (mdBusy) begin
      if (mont_a !== capA || mont_b !== capB || mont_start !== 1'b0) unstable++;
      waitLeft--;
      waitCycles++;
      if (waitLeft == 0) begin
        mont_done   = 1'b1;
        mont_result = capR;
        mdBusy      = 1'b0;
      end
    end else if (mont_start === 1'b1) begin
      startCount++;
      capA     = mont_a;
      capB     = mont_b;
      capR     = montMul(mont_a, mont_b, curM);
      waitLeft = int'($urandom_range(1, 3));
      mdBusy   = 1'b1;
    end
    if (done === 1'b1) begin
      doneCount++;
      if (doneCount == 1) begin
        doneCycle    = cycle;
        doneBusy     = busy;
        doneResult   = result;
        donePrevBusy = lastBusy;
      end
    end
    lastBusy = busy;
  endtask

  task automatic loadOperands(input logic [W-1:0] x, input logic [EW-1:0] e,
                              input logic [W-1:0] m);
    logic [W2-1:0] mm, rr;
    mm        = {{W{1'b0}}, m};
    rr        = (W2'(1) << W) % mm;
    in_rmodm  = rr[W-1:0];
    rr        = (rr * rr) % mm;
    in_r2modm = rr[W-1:0];
    in_x      = x;
    in_e      = e;
    in_m      = m;
    curM      = m;
  endtask

  // Runs one exponentiation; secondAt > 0 re-pulses start with X=3 that many cycles in.
  task automatic applyStimulus(input string tag, input logic [W-1:0] x,
                               input logic [EW-1:0] e, input logic [W-1:0] m,
                               input int secondAt);
    logic [W-1:0] expRes;
    int expN, sCycle;
    loadOperands(x, e, m);
    expRes     = modExp(x, e, m);
    expN       = expectedN(e);
    startCount = 0;
    waitCycles = 0;
    unstable   = 0;
    doneCount  = 0;
    sCycle     = cycle;
    start      = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, "_busyAfterStart"}, W'(busy), W'(1));
    while (doneCount == 0 && (cycle - sCycle) < 20000) begin
      if (secondAt > 0 && (cycle - sCycle) == secondAt) begin
        in_x  = W'(3);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    checkOutput({tag, "_doneSeen"}, W'(doneCount), W'(1));
    checkOutput({tag, "_result"}, doneResult, expRes);
    checkOutput({tag, "_multCount"}, W'(startCount), W'(expN));
    checkOutput({tag, "_latency"}, W'(doneCycle - sCycle), W'(1 + expN + waitCycles));
    checkOutput({tag, "_operandsStable"}, W'(unstable), W'(0));
    checkOutput({tag, "_busyAtDone"}, W'(doneBusy), W'(0));
    checkOutput({tag, "_busyBeforeDone"}, W'(donePrevBusy), W'(1));
    checkOutput({tag, "_montM"}, mont_m, m);
    for (int i = 0; i < 3; i++) tick();
    checkOutput({tag, "_singleDone"}, W'(doneCount), W'(1));
    checkOutput({tag, "_resultHeld"}, result, expRes);
  endtask

  initial begin
    logic [W-1:0] rm, rx;
    logic [EW-1:0] re;
    int guard;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_done", W'(done), W'(0));
    checkOutput("rst_result", result, W'(0));
    checkOutput("rst_montStart", W'(mont_start), W'(0));
    checkOutput("rst_montA", mont_a, W'(0));
    checkOutput("rst_montB", mont_b, W'(0));
    checkOutput("rst_montM", mont_m, W'(0));
    reset = 1'b0;
    tick();

    applyStimulus("basic", W'(2), EW'(5), W'(13), 0);
    applyStimulus("zeroExp", W'(2), EW'(0), W'(13), 0);
    applyStimulus("unitExp", W'(2), EW'(1), W'(13), 0);
    applyStimulus("startWhileBusy", W'(2), EW'(5), W'(13), 20);

    // Abort in the third WAIT phase, then confirm a clean restart
    loadOperands(W'(2), EW'(5), W'(13));
    startCount = 0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(startCount == 3 && mdBusy) && guard < 5000) begin
      tick();
      guard++;
    end
    checkOutput("abort_reachedThirdMult", W'(startCount), W'(3));
    tick();
    reset = 1'b1;
    tick();
    checkOutput("abort_busy", W'(busy), W'(0));
    checkOutput("abort_montStart", W'(mont_start), W'(0));
    checkOutput("abort_result", result, W'(0));
    checkOutput("abort_done", W'(done), W'(0));
    checkOutput("abort_montA", mont_a, W'(0));
    checkOutput("abort_montM", mont_m, W'(0));
    reset = 1'b0;
    tick();
    applyStimulus("afterAbort", W'(2), EW'(5), W'(13), 0);

    for (int n = 0; n < 2; n++) begin
      rm = randWide();
      rm[W-1] = 1'b1;
      rm[0]   = 1'b1;
      rx = randWide() % rm;
      re = randWide();
      applyStimulus($sformatf("fullWidth%0d", n), rx, re, rm, 0);
    end

    re = '0;
    re[17] = 1'b1;
    re[3]  = 1'b1;
    applyStimulus("sparseExp", randWide() % W'(1000003), re, W'(1000003), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
Sequencer for modular exponentiation, result = X^E mod M, using left-to-right binary square-and-multiply. It drives one external montgomery multiplier instance over its start/done interface. Operands are converted into and out of the Montgomery domain with caller-supplied R mod M and R^2 mod M, where R = 2^WIDTH. It sits between the RSA top level and the montgomery datapath.

Parameters:
WIDTH, 512, operand/modulus width in bits; must equal the multiplier width.
E_WIDTH, 512, exponent width in bits.
CNT_W, $clog2(E_WIDTH), width of the exponent bit index.

Ports:
clk  in  1  clock; all logic rising-edge.
reset  in  1  synchronous, active-high; also routed to the multiplier instance.
start  in  1  one-cycle request; sampled only in IDLE.
in_x  in  WIDTH  base; requirement in_x < in_m.
in_e  in  E_WIDTH  exponent.
in_m  in  WIDTH  modulus; must be odd.
in_rmodm  in  WIDTH  R mod M.
in_r2modm  in  WIDTH  R^2 mod M.
busy  out  1  high from the accepted start until done.
done  out  1  one-cycle pulse when result is valid.
result  out  WIDTH  X^E mod M; held until the next accepted start.
mont_start  out  1  one-cycle pulse to the multiplier.
mont_a  out  WIDTH  multiplier operand A.
mont_b  out  WIDTH  multiplier operand B.
mont_m  out  WIDTH  modulus; registered copy of in_m.
mont_result  in  WIDTH  multiplier result.
mont_done  in  1  multiplier completion pulse.

Behaviour:
- Reset values: busy=0, done=0, result=0, mont_start=0, mont_a=0, mont_b=0, mont_m=0; state=IDLE.
- IDLE, start=1:
  - Register in_x, in_e, in_m, in_rmodm and in_r2modm.
  - Set acc = in_rmodm, idx = E_WIDTH-1, busy=1.
  - Go to CONV_IN.
  - start while busy is ignored; operands are not resampled.
- Every multiply state has two phases: ISSUE then WAIT.
  - ISSUE: drive mont_a/mont_b and pulse mont_start for exactly one cycle, then enter WAIT.
  - WAIT: hold mont_a/mont_b stable; mont_done is ignored in every other phase and state.
  - On mont_done in WAIT: capture mont_result into the state's destination and transition on the same edge.
- CONV_IN: xm = mont(x, r2modm). Next state: SQR.
- SQR: acc = mont(acc, acc). Next state: MUL if e[idx]=1, otherwise the bit-step rule below.
- MUL: acc = mont(acc, xm). Next state: the bit-step rule below.
- Bit-step rule:
  - idx==0 -> CONV_OUT.
  - Otherwise idx decrements and the next state is SQR.
- CONV_OUT: acc = mont(acc, 1), with mont_b = WIDTH'(1). Next state: FIN.
- FIN, one cycle: result <= acc, done=1 for that cycle, busy=0, then IDLE.
- Multiplication count N = 2 + E_WIDTH + popcount(E).
- Controller overhead: one ISSUE cycle per multiplication, plus one cycle into CONV_IN and the FIN cycle.
- E=0 gives result=1 (M>1).
- reset mid-operation: abort on the next edge to IDLE with all outputs at reset values. Any in-flight multiplier result is discarded; the multiplier is reset on the same edge.
- done and start cannot coincide; a new start is accepted the cycle after FIN.

Optional Feature:
SKIP_LEADING_ZEROS_EN
- Defined:
  - After the CONV_IN capture, idx loads the index of the most-significant set bit of E instead of E_WIDTH-1.
  - If E=0, go directly from CONV_IN to CONV_OUT.
  - N = 2 + (msb+1) + popcount(E); N = 2 for E=0.
- Undefined: all E_WIDTH bits are processed.
- result is identical in both builds.

Decomposition:
- Package mont_exp_pkg holds:
  - the state enum: IDLE, CONV_IN, SQR, MUL, CONV_OUT, FIN;
  - a phase enum: ISSUE, WAIT;
  - WIDTH/E_WIDTH defaults.
- One sub-module, exp_msb_detect: combinational priority encoder that outputs msb index and a zero flag, instantiated only under SKIP_LEADING_ZEROS_EN.
- The multiplier is instantiated outside this block.

Test Plan:
- Basic exponentiation:
  - Stimulus: WIDTH=512; M=13, X=2, E=5, rmodm=9, r2modm=3; pulse start.
  - Response: result=6, one done pulse, busy falls with done.
  - Count of mont_start pulses: 516 without the macro, 7 with it.
- Zero exponent: same M/R values, X=2, E=0 -> result=1. mont_start count: 514 without the macro, 2 with it.
- Unit exponent: E=1 -> result=2. With the macro, mont_start count=4.
- Start while busy:
  - Stimulus: pulse start with E=5, then pulse start again with X=3 at cycle 20.
  - Response: result=6; only one done pulse; the second start is ignored.
- Reset mid-operation:
  - Stimulus: assert reset during the 3rd WAIT phase.
  - Response: next edge gives busy=0, mont_start=0, result=0.
  - A fresh start with X=2, E=5 then returns 6.
- Full-width operands:
  - Stimulus: 512-bit X, E and odd M, with rmodm/r2modm from the test vector generator script.
  - Response: result matches the script output exactly. mont_a/mont_b are stable from each mont_start until the matching mont_done.
